// File: rtl/reg_file_scoreboard_if.sv
// Bus bundle for reg_file_scoreboard: writeback commit, decode reservation,
// bypassed read ports and architectural status outputs.
interface reg_file_scoreboard_if #(
  parameter int NREGS = 16,
  parameter int WIDTH = 64,
  parameter int RIP_W = 32
);
  localparam int AW = $clog2(NREGS);

  // writeback / commit
  logic             wb_valid;
  logic [RIP_W-1:0] wb_rip;
  logic [AW-1:0]    wb_dest;
  logic [WIDTH-1:0] wb_result;
  logic [AW-1:0]    wb_dest_sp;
  logic             wb_dest_sp_valid;
  logic [WIDTH-1:0] wb_result_sp;
  logic [AW-1:0]    wb_src1;
  logic             wb_src1_valid;
  logic [AW-1:0]    wb_src2;
  logic             wb_src2_valid;

  // decode reservation
  logic             rsv_valid;
  logic [AW-1:0]    rsv_src1;
  logic             rsv_src1_valid;
  logic [AW-1:0]    rsv_src2;
  logic             rsv_src2_valid;
  logic [AW-1:0]    rsv_dest;
  logic [AW-1:0]    rsv_dest_sp;
  logic             rsv_dest_sp_valid;
  logic             rsv_ready;

  // read ports
  logic [AW-1:0]    rd_addr1;
  logic [AW-1:0]    rd_addr2;
  logic [WIDTH-1:0] rd_data1;
  logic [WIDTH-1:0] rd_data2;

  // status
  logic [NREGS-1:0] in_use;
  logic [63:0]      retire_count;
  logic [RIP_W-1:0] last_rip;

  modport master (
    output wb_valid, wb_rip, wb_dest, wb_result, wb_dest_sp, wb_dest_sp_valid,
           wb_result_sp, wb_src1, wb_src1_valid, wb_src2, wb_src2_valid,
           rsv_valid, rsv_src1, rsv_src1_valid, rsv_src2, rsv_src2_valid,
           rsv_dest, rsv_dest_sp, rsv_dest_sp_valid, rd_addr1, rd_addr2,
    input  rsv_ready, rd_data1, rd_data2, in_use, retire_count, last_rip
  );

  modport slave (
    input  wb_valid, wb_rip, wb_dest, wb_result, wb_dest_sp, wb_dest_sp_valid,
           wb_result_sp, wb_src1, wb_src1_valid, wb_src2, wb_src2_valid,
           rsv_valid, rsv_src1, rsv_src1_valid, rsv_src2, rsv_src2_valid,
           rsv_dest, rsv_dest_sp, rsv_dest_sp_valid, rd_addr1, rd_addr2,
    output rsv_ready, rd_data1, rd_data2, in_use, retire_count, last_rip
  );
endinterface

// File: rtl/reg_file_scoreboard.sv
// Architectural register file with in-use scoreboard. Commits up to two
// results per cycle, releases retiring registers, grants decode reservations
// only when every touched register is free, and bypasses same-cycle commits
// onto the read ports.
module reg_file_scoreboard #(
  parameter int NREGS = 16,
  parameter int WIDTH = 64,
  parameter int RIP_W = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  reg_file_scoreboard_if.slave bus
);
  localparam int AW = $clog2(NREGS);

  logic [WIDTH-1:0] regs [NREGS];
  logic [NREGS-1:0] in_use_q;
  logic [63:0]      retire_count_q;
  logic [RIP_W-1:0] last_rip_q;

  // A commit seen while reset is low is dropped, including its bypass and
  // scoreboard release, so every output reads as reset state immediately.
  logic             commit;
  logic [NREGS-1:0] wb_clr;
  logic [NREGS-1:0] eff_in_use;
  logic [NREGS-1:0] rsv_mask;
  logic             rsv_ready;
  logic             rsv_fire;

  assign commit = bus.wb_valid & reset_n;

  // Registers released by this cycle's commit.
  always_comb begin
    wb_clr = '0;
    if (commit) begin
      wb_clr[bus.wb_dest] = 1'b1;
      if (bus.wb_dest_sp_valid) wb_clr[bus.wb_dest_sp] = 1'b1;
      if (bus.wb_src1_valid)    wb_clr[bus.wb_src1]    = 1'b1;
      if (bus.wb_src2_valid)    wb_clr[bus.wb_src2]    = 1'b1;
    end
  end

  assign eff_in_use = in_use_q & ~wb_clr;

  // Registers the requesting instruction touches; computed even without
  // rsv_valid so decode can look at rsv_ready ahead of asserting a request.
  always_comb begin
    rsv_mask = '0;
    rsv_mask[bus.rsv_dest] = 1'b1;
    if (bus.rsv_src1_valid)    rsv_mask[bus.rsv_src1]    = 1'b1;
    if (bus.rsv_src2_valid)    rsv_mask[bus.rsv_src2]    = 1'b1;
    if (bus.rsv_dest_sp_valid) rsv_mask[bus.rsv_dest_sp] = 1'b1;
  end

  assign rsv_ready = ~|(eff_in_use & rsv_mask);
  assign rsv_fire  = bus.rsv_valid & rsv_ready;

  // Scoreboard update: commit clears first, reservation sets win on overlap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_use_q <= '0;
    end else begin
      in_use_q <= eff_in_use | (rsv_fire ? rsv_mask : '0);
    end
  end

  // Register array write; primary is assigned last so it wins a shared address.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (commit) begin
      if (bus.wb_dest_sp_valid) regs[bus.wb_dest_sp] <= bus.wb_result_sp;
      regs[bus.wb_dest] <= bus.wb_result;
    end
  end

  // Retirement bookkeeping; the counter wraps naturally at 2^64.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      retire_count_q <= '0;
      last_rip_q     <= '0;
    end else if (commit) begin
      retire_count_q <= retire_count_q + 64'd1;
      last_rip_q     <= bus.wb_rip;
    end
  end

  // Read port 1 with same-cycle commit bypass (primary over special).
  always_comb begin
    bus.rd_data1 = regs[bus.rd_addr1];
    if (commit && bus.wb_dest_sp_valid && (bus.rd_addr1 == bus.wb_dest_sp))
      bus.rd_data1 = bus.wb_result_sp;
    if (commit && (bus.rd_addr1 == bus.wb_dest))
      bus.rd_data1 = bus.wb_result;
  end

  // Read port 2 with same-cycle commit bypass (primary over special).
  always_comb begin
    bus.rd_data2 = regs[bus.rd_addr2];
    if (commit && bus.wb_dest_sp_valid && (bus.rd_addr2 == bus.wb_dest_sp))
      bus.rd_data2 = bus.wb_result_sp;
    if (commit && (bus.rd_addr2 == bus.wb_dest))
      bus.rd_data2 = bus.wb_result;
  end

  assign bus.rsv_ready    = rsv_ready;
  assign bus.in_use       = in_use_q;
  assign bus.retire_count = retire_count_q;
  assign bus.last_rip     = last_rip_q;

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Directed bench for reg_file_scoreboard: reset state, reservation stalls,
// same-cycle release, dual commit with bypass, counter wrap, async reset.
module tb_reg_file_scoreboard;
  logic clk;
  logic reset_n;
  int   n_tests;
  int   n_fail;

  reg_file_scoreboard_if bus ();

  reg_file_scoreboard dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.wb_valid = 1'b0;          bus.wb_rip = '0;
    bus.wb_dest = '0;             bus.wb_result = '0;
    bus.wb_dest_sp = '0;          bus.wb_dest_sp_valid = 1'b0;
    bus.wb_result_sp = '0;
    bus.wb_src1 = '0;             bus.wb_src1_valid = 1'b0;
    bus.wb_src2 = '0;             bus.wb_src2_valid = 1'b0;
    bus.rsv_valid = 1'b0;
    bus.rsv_src1 = '0;            bus.rsv_src1_valid = 1'b0;
    bus.rsv_src2 = '0;            bus.rsv_src2_valid = 1'b0;
    bus.rsv_dest = '0;
    bus.rsv_dest_sp = '0;         bus.rsv_dest_sp_valid = 1'b0;
  endtask

  task automatic commit(input logic [3:0] dest, input logic [63:0] res, input logic [31:0] rip);
    bus.wb_valid = 1'b1; bus.wb_dest = dest; bus.wb_result = res; bus.wb_rip = rip;
  endtask

  task automatic reserve4(input logic [3:0] s1, input logic [3:0] s2,
                          input logic [3:0] d, input logic [3:0] dsp);
    bus.rsv_valid = 1'b1;
    bus.rsv_src1 = s1; bus.rsv_src1_valid = 1'b1;
    bus.rsv_src2 = s2; bus.rsv_src2_valid = 1'b1;
    bus.rsv_dest = d;
    bus.rsv_dest_sp = dsp; bus.rsv_dest_sp_valid = 1'b1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset_n = 1'b0;
    idle();
    bus.rd_addr1 = 4'd3;
    bus.rd_addr2 = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_use", bus.in_use, 64'h0);
    check("rst_retire", bus.retire_count, 64'h0);
    check("rst_last_rip", bus.last_rip, 64'h0);
    check("rst_rd1", bus.rd_data1, 64'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // Reservation src1=1 dest=2 from empty scoreboard
    @(negedge clk);
    bus.rsv_valid = 1'b1; bus.rsv_src1 = 4'd1; bus.rsv_src1_valid = 1'b1; bus.rsv_dest = 4'd2;
    #1;
    check("t1_rd1", bus.rd_data1, 64'h0);
    check("t1_ready", bus.rsv_ready, 64'h1);
    @(posedge clk); #1;
    idle();
    check("t1_in_use", bus.in_use, 64'h0006);

    // dest=2 busy: stall with no state change
    @(negedge clk);
    bus.rsv_valid = 1'b1; bus.rsv_dest = 4'd2;
    #1;
    check("t2_stall_ready", bus.rsv_ready, 64'h0);
    @(posedge clk); #1;
    check("t2_stall_in_use", bus.in_use, 64'h0006);
    // Same-cycle commit to reg 2 frees it; reservation re-sets it
    @(negedge clk);
    commit(4'd2, 64'hDEAD, 32'h100);
    bus.rd_addr1 = 4'd2;
    #1;
    check("t2_ready_freed", bus.rsv_ready, 64'h1);
    check("t2_bypass", bus.rd_data1, 64'hDEAD);
    @(posedge clk); #1;
    idle();
    check("t2_in_use", bus.in_use, 64'h0006);
    check("t2_array", bus.rd_data1, 64'hDEAD);
    check("t2_retire", bus.retire_count, 64'd1);
    check("t2_rip", bus.last_rip, 64'h100);

    // Primary and special to the same register: primary wins
    @(negedge clk);
    commit(4'd5, 64'h11, 32'h104);
    bus.wb_dest_sp = 4'd5; bus.wb_dest_sp_valid = 1'b1; bus.wb_result_sp = 64'h22;
    bus.rd_addr1 = 4'd5; bus.rd_addr2 = 4'd5;
    #1;
    check("t3_bypass1", bus.rd_data1, 64'h11);
    check("t3_bypass2", bus.rd_data2, 64'h11);
    @(posedge clk); #1;
    idle();
    check("t3_array", bus.rd_data1, 64'h11);
    check("t3_retire", bus.retire_count, 64'd2);

    // Reserve src1=7 dest=0 so the next commit has bits to release
    @(negedge clk);
    bus.rsv_valid = 1'b1; bus.rsv_src1 = 4'd7; bus.rsv_src1_valid = 1'b1; bus.rsv_dest = 4'd0;
    #1;
    check("t4_pre_ready", bus.rsv_ready, 64'h1);
    @(posedge clk); #1;
    idle();
    check("t4_pre_in_use", bus.in_use, 64'h0087);
    // Dual commit: dest=0, sp=2, src1=7 valid, src2=1 invalid (must not clear)
    @(negedge clk);
    commit(4'd0, 64'hAA, 32'h200);
    bus.wb_dest_sp = 4'd2; bus.wb_dest_sp_valid = 1'b1; bus.wb_result_sp = 64'hBB;
    bus.wb_src1 = 4'd7; bus.wb_src1_valid = 1'b1;
    bus.wb_src2 = 4'd1; bus.wb_src2_valid = 1'b0;
    bus.rd_addr1 = 4'd0; bus.rd_addr2 = 4'd2;
    #1;
    check("t4_bypass_pri", bus.rd_data1, 64'hAA);
    check("t4_bypass_sp", bus.rd_data2, 64'hBB);
    @(posedge clk); #1;
    idle();
    check("t4_in_use", bus.in_use, 64'h0002);
    check("t4_reg0", bus.rd_data1, 64'hAA);
    check("t4_reg2", bus.rd_data2, 64'hBB);
    check("t4_retire", bus.retire_count, 64'd3);
    check("t4_rip", bus.last_rip, 64'h200);

    // Invalid fields pointing at busy reg 1 are ignored; rsv_ready without rsv_valid
    @(negedge clk);
    bus.rsv_dest = 4'd3;
    bus.rsv_src2 = 4'd1; bus.rsv_src2_valid = 1'b0;
    bus.rsv_dest_sp = 4'd1; bus.rsv_dest_sp_valid = 1'b0;
    #1;
    check("t5_invalid_ignored", bus.rsv_ready, 64'h1);
    bus.rsv_dest_sp_valid = 1'b1;
    #1;
    check("t5_sp_busy", bus.rsv_ready, 64'h0);
    bus.rsv_dest_sp_valid = 1'b0;
    bus.rsv_dest = 4'd1;
    #1;
    check("t5_dest_busy", bus.rsv_ready, 64'h0);
    @(posedge clk); #1;
    idle();
    check("t5_in_use", bus.in_use, 64'h0002);

    // Retire counter wrap from all-ones
    @(negedge clk);
    force dut.retire_count_q = {64{1'b1}};
    #1;
    release dut.retire_count_q;
    #1;
    check("t6_preload", bus.retire_count, 64'hFFFF_FFFF_FFFF_FFFF);
    commit(4'd4, 64'h44, 32'h300);
    @(posedge clk); #1;
    idle();
    check("t6_wrap", bus.retire_count, 64'h0);
    check("t6_rip", bus.last_rip, 64'h300);

    // Fill scoreboard: first group needs reg 1, released by same-cycle commit
    @(negedge clk);
    reserve4(4'd0, 4'd1, 4'd2, 4'd3);
    commit(4'd1, 64'h1111, 32'h304);
    #1;
    check("t7_ready_g0", bus.rsv_ready, 64'h1);
    @(posedge clk); #1;
    idle();
    for (int g = 1; g < 4; g++) begin
      @(negedge clk);
      reserve4(4'(4*g), 4'(4*g+1), 4'(4*g+2), 4'(4*g+3));
      @(posedge clk); #1;
      idle();
    end
    check("t7_full", bus.in_use, 64'hFFFF);
    check("t7_retire", bus.retire_count, 64'd1);

    // Async reset mid-commit: everything clears without a clock edge
    @(negedge clk);
    commit(4'd9, 64'h99, 32'h400);
    bus.rd_addr1 = 4'd9; bus.rd_addr2 = 4'd0;
    bus.rsv_dest = 4'd9;
    #2;
    reset_n = 1'b0;
    #1;
    check("t8_in_use", bus.in_use, 64'h0);
    check("t8_retire", bus.retire_count, 64'h0);
    check("t8_rip", bus.last_rip, 64'h0);
    check("t8_rd1", bus.rd_data1, 64'h0);
    check("t8_rd2", bus.rd_data2, 64'h0);
    check("t8_ready", bus.rsv_ready, 64'h1);
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    reset_n = 1'b1;
    bus.rd_addr1 = 4'd2; bus.rd_addr2 = 4'd9;
    @(posedge clk); #1;
    check("t8_reg2_after", bus.rd_data1, 64'h0);
    check("t8_reg9_after", bus.rd_data2, 64'h0);
    check("t8_in_use_after", bus.in_use, 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
